// File: rtl/paddle_vertical.sv
// Per-player paddle vertical stage: latches the paddle position each frame,
// counts scan lines down to the paddle top and emits the paddle window and segment bits.
//
// state | meaning
// BLANK | vertical blanking; offset counter reloaded from the latched position
// WAIT  | active video above the paddle; offset counts down one per line
// DRAW  | paddle window; segment counter steps one per line
// DONE  | below the paddle; outputs idle until the next blanking
module paddle_vertical #(
  parameter int         PAD_LINES = 15,
  parameter logic [7:0] POS_MIN   = 8'd0,
  parameter logic [7:0] POS_MAX   = 8'(239 - PAD_LINES)
) (
  input  logic       i_clk7_159,
  input  logic       i_rst,
  input  logic       i_hsync_n,
  input  logic       i_vblank,
  input  logic [7:0] i_pad_pos,
  input  logic       i_pad_hwin,
  output logic       o_pad,
  output logic       o_padvid,
  output logic       o_b,
  output logic       o_c,
  output logic       o_d
);

  typedef enum logic [1:0] {
    S_BLANK = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAW  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEG_LAST = 4'(PAD_LINES - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_hsync_q;
  logic       r_vblank_q;
  logic [7:0] r_pos_lat;
  logic [7:0] r_offs;
  logic [7:0] w_offs_nxt;
  logic [3:0] r_seg;
  logic [3:0] w_seg_nxt;
  logic       w_line_tick;
  logic       w_vblank_rise;
  logic [7:0] w_pos_clamped;

  assign w_line_tick   = r_hsync_q & ~i_hsync_n;
  assign w_vblank_rise = i_vblank & ~r_vblank_q;

  // Inclusive compares keep the bounds meaningful even when a limit is zero.
  assign w_pos_clamped = (i_pad_pos <= POS_MIN) ? POS_MIN :
                         (i_pad_pos >= POS_MAX) ? POS_MAX : i_pad_pos;

  always_ff @(posedge i_clk7_159 or posedge i_rst) begin
    if (i_rst) begin
      r_hsync_q  <= 1'b1;
      r_vblank_q <= 1'b0;
      r_pos_lat  <= POS_MIN;
    end else begin
      r_hsync_q  <= i_hsync_n;
      r_vblank_q <= i_vblank;
      if (w_vblank_rise) begin
        r_pos_lat <= w_pos_clamped;
      end
    end
  end

  always_ff @(posedge i_clk7_159 or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_BLANK;
      r_offs  <= 8'd0;
      r_seg   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_offs  <= w_offs_nxt;
      r_seg   <= w_seg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_offs_nxt  = r_offs;
    w_seg_nxt   = r_seg;
    // Blanking overrides everything, including a coincident line tick.
    if (i_vblank) begin
      w_state_nxt = S_BLANK;
      w_offs_nxt  = r_pos_lat;
      w_seg_nxt   = 4'd0;
    end else begin
      case (r_state)
        S_BLANK: begin
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (w_line_tick) begin
            if (r_offs == 8'd0) begin
              w_state_nxt = S_DRAW;
              w_seg_nxt   = 4'd0;
            end else begin
              w_offs_nxt = r_offs - 8'd1;
            end
          end
        end
        S_DRAW: begin
          if (w_line_tick) begin
            if (r_seg == SEG_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_seg_nxt = r_seg + 4'd1;
            end
          end
        end
        S_DONE: begin
          w_seg_nxt = SEG_LAST;
        end
        default: begin
          w_state_nxt = S_BLANK;
        end
      endcase
    end
  end

  assign o_pad              = (r_state == S_DRAW);
  assign o_padvid           = o_pad & i_pad_hwin;
  assign {o_d, o_c, o_b}    = o_pad ? r_seg[3:1] : 3'b000;

endmodule

// File: tb/tb_paddle_vertical.sv
// Bench for paddle_vertical: drives synthetic video timing and compares every line
// against a window model computed from the latched, clamped paddle position.
module tb_paddle_vertical;

  localparam int LINE = 20;
  localparam int ACT  = 240;
  localparam int PADL = 15;
  localparam int PMAX = 239 - PADL;

  logic       clk = 1'b0;
  logic       rst;
  logic       hsync_n;
  logic       vblank;
  logic       hwin;
  logic [7:0] pos;
  logic       pad;
  logic       padvid;
  logic       b;
  logic       c;
  logic       d;

  int checks   = 0;
  int failures = 0;
  int exp_lat  = 0;
  int hw0      = 8;

  always #5 clk = ~clk;

  paddle_vertical dut (
    .i_clk7_159 (clk),
    .i_rst      (rst),
    .i_hsync_n  (hsync_n),
    .i_vblank   (vblank),
    .i_pad_pos  (pos),
    .i_pad_hwin (hwin),
    .o_pad      (pad),
    .o_padvid   (padvid),
    .o_b        (b),
    .o_c        (c),
    .o_d        (d)
  );

  function automatic int clamp(input int p);
    return (p > PMAX) ? PMAX : p;
  endfunction

  task automatic check(input string tag, input int ln, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s line=%0d observed=%0d expected=%0d", tag, ln, obs, exp);
    end
  endtask

  // One scan line; ln<0 marks a blanking line where the paddle must be absent.
  task automatic run_line(input int ln, input bit chk, input int vb_set, input bit do_rst, input int chg);
    int ep;
    int edcb;
    bit live;
    live = chk;
    ep   = (ln >= exp_lat && ln < exp_lat + PADL) ? 1 : 0;
    edcb = (ep != 0) ? (ln - exp_lat) / 2 : 0;
    for (int cy = 0; cy < LINE; cy++) begin
      @(posedge clk);
      #1;
      hsync_n = (cy >= 3);
      hwin    = (cy >= hw0 && cy < hw0 + 4);
      if (cy == 12 && vb_set >= 0) vblank = (vb_set != 0);
      if (cy == 6 && chg >= 0) pos = 8'(chg);
      if (do_rst && cy == 10) begin
        rst = 1'b1;
        #1;
        check("rst_pad", ln, {7'd0, pad}, 8'd0);
        check("rst_padvid", ln, {7'd0, padvid}, 8'd0);
        check("rst_dcb", ln, {5'd0, d, c, b}, 8'd0);
        live = 1'b0;
      end
      if (do_rst && cy == 14) rst = 1'b0;
      @(negedge clk);
      if (live && cy == 1) begin
        check("pad", ln, {7'd0, pad}, 8'(ep));
        check("dcb", ln, {5'd0, d, c, b}, 8'(edcb));
      end
      if (live && cy >= 1) begin
        check("padvid", ln, {7'd0, padvid}, {7'd0, (ep != 0) & hwin});
      end
    end
  endtask

  task automatic run_frame(input int nvb, input int rst_line, input int chg_line, input int chg_pos);
    bit live;
    live    = 1'b1;
    hw0     = $urandom_range(4, LINE - 6);
    exp_lat = clamp(int'(pos));
    for (int l = 0; l < nvb; l++) begin
      run_line(-1, 1'b1, (l == 0) ? 1 : ((l == nvb - 1) ? 0 : -1), 1'b0, -1);
    end
    for (int l = 0; l < ACT; l++) begin
      run_line(l, live, -1, (l == rst_line), (l == chg_line) ? chg_pos : -1);
      if (l == rst_line) live = 1'b0;
    end
  endtask

  initial begin
    int rp;
    rst     = 1'b1;
    hsync_n = 1'b1;
    vblank  = 1'b1;
    hwin    = 1'b0;
    pos     = 8'd100;
    repeat (3) @(posedge clk);
    #1;
    check("reset_pad", -1, {7'd0, pad}, 8'd0);
    check("reset_padvid", -1, {7'd0, padvid}, 8'd0);
    check("reset_dcb", -1, {5'd0, d, c, b}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Long blanking hold, then two frames at line 100.
    run_frame(245, -1, -1, 0);
    run_frame(4, -1, -1, 0);

    pos = 8'd0;
    run_frame(4, -1, -1, 0);
    pos = 8'd255;
    run_frame(4, -1, -1, 0);

    // Mid-frame position change only takes effect on the following frame.
    pos = 8'd50;
    run_frame(4, -1, 120, 150);
    run_frame(4, -1, -1, 0);

    for (int k = 0; k < 3; k++) begin
      pos = 8'($urandom_range(0, 255));
      rp  = $urandom_range(0, 255);
      run_frame(4, -1, (k == 1) ? 60 : -1, rp);
    end

    // Reset while drawing; the next full frame must draw at 100 again.
    pos = 8'd100;
    run_frame(4, 105, -1, 0);
    run_frame(4, -1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
